// File: rtl/buffer_loader.sv
// Packs a byte stream into tiles and writes exactly TILE_COUNT tiles per load.
// Optional BUFFER_LOADER_CHECKSUM_EN adds a 16-bit sum of accepted bytes.
`timescale 1ns/1ps
module buffer_loader #(
   parameter int BUFFER_WIDTH = 1024,
   parameter int BUFFER_COUNT = 2,
   parameter int TILE_WIDTH   = 256,
   parameter int DATA_WIDTH   = 8,
   parameter int TILE_SIZE    = 32,
   localparam int TILE_COUNT  = BUFFER_WIDTH / TILE_WIDTH,
   localparam int ELEM_COUNT  = BUFFER_WIDTH / DATA_WIDTH,
   localparam int ID_W        = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1,
   localparam int LEN_W       = $clog2(ELEM_COUNT) + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ID_W-1:0]       buf_id,
   input  logic [LEN_W-1:0]      length,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [TILE_WIDTH-1:0] wr_data,
   output logic [ID_W-1:0]       wr_buffer,
   input  logic                  wr_done,
   output logic                  busy,
   output logic                  done,
`ifdef BUFFER_LOADER_CHECKSUM_EN
   output logic [15:0]           checksum,
`endif
   output logic                  error
);

   localparam int SLOT_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
   localparam int TCNT_W = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_WRITE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [TILE_WIDTH-1:0] tile_q, tile_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
   logic [LEN_W-1:0]      cons_q, cons_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic                  err_q, err_d;
   logic                  len_ok;
   logic                  hs;
   logic                  accept;

   assign len_ok   = (length != '0) && (length <= LEN_W'(ELEM_COUNT));
   assign accept   = (state_q == S_IDLE) && start && len_ok;
   assign in_ready = (state_q == S_FILL) && (cons_q < len_q);
   assign hs       = in_valid && in_ready;

   assign wr_en     = (state_q == S_WRITE);
   assign wr_data   = tile_q;
   assign wr_buffer = id_q;
   assign busy      = (state_q == S_FILL) || (state_q == S_WRITE) ||
                      (state_q == S_WAIT);
   assign done      = (state_q == S_DONE);
   assign error     = err_q;

   always_comb begin
      state_d = state_q;
      tile_d  = tile_q;
      slot_d  = slot_q;
      tcnt_d  = tcnt_q;
      cons_d  = cons_q;
      len_d   = len_q;
      id_d    = id_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len_ok) begin
                  id_d    = buf_id;
                  len_d   = length;
                  tile_d  = '0;
                  slot_d  = '0;
                  tcnt_d  = '0;
                  cons_d  = '0;
                  state_d = S_FILL;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_FILL: begin
            // A tile with no bytes left to consume goes out as zero padding
            if (hs) begin
               tile_d[int'(slot_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
               slot_d = slot_q + 1'b1;
               cons_d = cons_q + 1'b1;
               if ((slot_q == SLOT_W'(TILE_SIZE - 1)) ||
                   (cons_q + 1'b1 == len_q))
                  state_d = S_WRITE;
            end else if (cons_q >= len_q) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (tcnt_q == TCNT_W'(TILE_COUNT - 1)) begin
               state_d = S_WAIT;
            end else begin
               tcnt_d  = tcnt_q + 1'b1;
               tile_d  = '0;
               slot_d  = '0;
               state_d = S_FILL;
            end
         end
         S_WAIT: begin
            if (wr_done)
               state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         tile_q  <= '0;
         slot_q  <= '0;
         tcnt_q  <= '0;
         cons_q  <= '0;
         len_q   <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tile_q  <= tile_d;
         slot_q  <= slot_d;
         tcnt_q  <= tcnt_d;
         cons_q  <= cons_d;
         len_q   <= len_d;
         id_q    <= id_d;
         err_q   <= err_d;
      end
   end

`ifdef BUFFER_LOADER_CHECKSUM_EN
   logic [15:0] ck_q, ck_d;

   always_comb begin
      ck_d = ck_q;
      if (accept)
         ck_d = '0;
      else if (hs)
         ck_d = ck_q + 16'(in_data);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ck_q <= '0;
      else
         ck_q <= ck_d;
   end

   assign checksum = ck_q;
`endif

endmodule
